// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//   Line-granular write-back buffer between the data cache memory port and
//   Data_Memory. Evicted dirty lines are acknowledged as soon as they are
//   buffered, then drained to memory in FIFO order whenever the cache is
//   quiet. Reads that hit a buffered line are served locally; read misses
//   go to memory ahead of any pending drain.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   cache_enable_i         cache request valid, held until cache_ack_o
//   cache_write_i          1 = line write (eviction), 0 = line read
//   cache_addr_i           request byte address
//   cache_data_i           line to write
//   cache_ack_o            one-cycle completion pulse
//   cache_data_o           read line, valid with cache_ack_o and held after
//   mem_enable_o           memory request, held until mem_ack_i
//   mem_write_o            memory request type
//   mem_addr_o             line-aligned memory address
//   mem_data_o             memory write line
//   mem_ack_i              memory completion
//   mem_data_i             memory read line, sampled with mem_ack_i
//   empty_o / full_o       buffer occupancy flags
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cache_enable_i,
  input  logic              cache_write_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  input  logic [LINE_W-1:0] cache_data_i,
  output logic              cache_ack_o,
  output logic [LINE_W-1:0] cache_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W - 5;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACK    = 2'd1,
    S_RD_MEM = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e             state_q;
  logic [DEPTH-1:0]   valid_q;
  logic [IDX_W-1:0]   idx_q  [DEPTH];
  logic [LINE_W-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               cache_ack_q;
  logic [LINE_W-1:0]  cache_data_q;
  logic               mem_enable_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [LINE_W-1:0]  mem_data_q;

  logic [IDX_W-1:0]   req_idx_s;
  logic [DEPTH-1:0]   match_s;
  logic [PTR_W-1:0]   hit_ptr_s;
  logic               hit_s;
  logic               empty_s;
  logic               full_s;
  logic               start_drain_s;
  logic               unused_addr_s;

  assign req_idx_s     = cache_addr_i[ADDR_W-1:5];
  // Byte offset inside the line has no meaning for a line buffer.
  assign unused_addr_s = ^cache_addr_i[4:0];

  // Associative lookup; merging keeps at most one match, so OR-encoding is exact.
  always_comb begin
    match_s   = '0;
    hit_ptr_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_q[i] && (idx_q[i] == req_idx_s);
      hit_ptr_s  = hit_ptr_s | ({PTR_W{match_s[i]}} & PTR_W'(i));
    end
  end

  assign hit_s   = |match_s;
  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == FULL_CNT);

  // Drain when idle with data, or when a new line needs room in a full buffer.
  always_comb begin
    start_drain_s = 1'b0;
    if (cache_enable_i) begin
      start_drain_s = cache_write_i && !hit_s && full_s;
    end else begin
      start_drain_s = !empty_s;
    end
  end

  // Control FSM, line storage and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      cache_ack_q  <= 1'b0;
      cache_data_q <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      cache_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_drain_s) begin
            mem_enable_q <= 1'b1;
            mem_write_q  <= 1'b1;
            mem_addr_q   <= {idx_q[rd_ptr_q], 5'b00000};
            mem_data_q   <= data_q[rd_ptr_q];
            state_q      <= S_DRAIN;
          end else if (cache_enable_i && cache_write_i) begin
            if (hit_s) begin
              data_q[hit_ptr_s] <= cache_data_i;
            end else begin
              valid_q[wr_ptr_q] <= 1'b1;
              idx_q[wr_ptr_q]   <= req_idx_s;
              data_q[wr_ptr_q]  <= cache_data_i;
              wr_ptr_q          <= wr_ptr_q + 1'b1;
              count_q           <= count_q + 1'b1;
            end
            cache_ack_q <= 1'b1;
            state_q     <= S_ACK;
          end else if (cache_enable_i) begin
            if (hit_s) begin
              cache_data_q <= data_q[hit_ptr_s];
              cache_ack_q  <= 1'b1;
              state_q      <= S_ACK;
            end else begin
              mem_enable_q <= 1'b1;
              mem_write_q  <= 1'b0;
              mem_addr_q   <= {req_idx_s, 5'b00000};
              state_q      <= S_RD_MEM;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD_MEM: begin
          if (mem_ack_i) begin
            mem_enable_q <= 1'b0;
            cache_data_q <= mem_data_i;
            cache_ack_q  <= 1'b1;
            state_q      <= S_ACK;
          end
        end
        S_DRAIN: begin
          if (mem_ack_i) begin
            mem_enable_q      <= 1'b0;
            mem_write_q       <= 1'b0;
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + 1'b1;
            count_q           <= count_q - 1'b1;
            state_q           <= S_IDLE;
          end
        end
        // The request being acked is still asserting enable; skip it.
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cache_ack_o  = cache_ack_q;
  assign cache_data_o = cache_data_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign empty_o      = empty_s;
  assign full_o       = full_s;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: a table of back-to-back cache
// operations with memory stalled, followed by hand-written multi-cycle
// sequences for eviction, full-buffer stall, drain order, read priority and
// reset in the middle of a drain.
module tb_dcache_write_buffer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cache_enable_i;
  logic         cache_write_i;
  logic [31:0]  cache_addr_i;
  logic [255:0] cache_data_i;
  logic         cache_ack_o;
  logic [255:0] cache_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;
  logic         empty_o;
  logic         full_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] D_AA = {32{8'hAA}};
  localparam logic [255:0] D_A  = {8{32'hA1A1_0020}};
  localparam logic [255:0] D_B  = {8{32'hB2B2_0020}};
  localparam logic [255:0] D_0  = {8{32'hC0C0_0000}};
  localparam logic [255:0] D_2  = {8{32'hC2C2_0040}};
  localparam logic [255:0] D_3  = {8{32'hC3C3_0060}};
  localparam logic [255:0] D_E  = {8{32'hE8E8_0080}};
  localparam logic [255:0] D_R  = {8{32'h5EAD_00E0}};
  localparam logic [255:0] D_P  = {8{32'h1010_0100}};
  localparam logic [255:0] D_Q  = {8{32'h1212_0120}};

  typedef struct packed {
    logic         w;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [3:0]   lat;
    logic [255:0] rdata;
    logic         empty;
    logic         full;
  } vec_t;

  vec_t tbl [9];

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(32), .LINE_W(256)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cache_enable_i (cache_enable_i),
    .cache_write_i  (cache_write_i),
    .cache_addr_i   (cache_addr_i),
    .cache_data_i   (cache_data_i),
    .cache_ack_o    (cache_ack_o),
    .cache_data_o   (cache_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i),
    .empty_o        (empty_o),
    .full_o         (full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cache_req(input logic w, input logic [31:0] a, input logic [255:0] d);
    cache_enable_i = 1'b1;
    cache_write_i  = w;
    cache_addr_i   = a;
    cache_data_i   = d;
  endtask

  // Count falling edges until cache_ack_o is seen; -1 on timeout.
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!cache_ack_o && lat < 40);
    if (!cache_ack_o) lat = -1;
  endtask

  // Wait for a memory request, check it, hold it 'hold' cycles, then ack it.
  task automatic mem_serve(input string nm, input logic exp_w, input logic [31:0] exp_a,
                           input logic chk_d, input logic [255:0] exp_d, input int hold,
                           input logic [255:0] rdata, output int lat);
    logic stable;
    lat = 0;
    while (!mem_enable_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    chk({nm, " en"}, mem_enable_o, 1'b1);
    chk({nm, " wr"}, mem_write_o, exp_w);
    chk({nm, " addr"}, mem_addr_o, exp_a);
    if (chk_d) chk({nm, " data"}, mem_data_o, exp_d);
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk_i);
      if (mem_enable_o !== 1'b1 || mem_write_o !== exp_w || mem_addr_o !== exp_a) stable = 1'b0;
    end
    chk({nm, " stable"}, stable, 1'b1);
    mem_data_i = rdata;
    mem_ack_i  = 1'b1;
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    chk({nm, " en drop"}, mem_enable_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;

    tbl[0] = '{1'b1, 32'h0000_0020, D_A, 4'd1, 256'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0020, 256'd0, 4'd2, D_A, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0020, D_B, 4'd2, 256'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0020, 256'd0, 4'd2, D_B, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_0000, D_0, 4'd2, 256'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0040, D_2, 4'd2, 256'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0000_0044, 256'd0, 4'd2, D_2, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h0000_0060, D_3, 4'd2, 256'd0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 32'h0000_0060, 256'd0, 4'd2, D_3, 1'b0, 1'b1};

    rst_i = 1'b1;
    cache_enable_i = 1'b0;
    cache_write_i  = 1'b0;
    cache_addr_i   = 32'd0;
    cache_data_i   = 256'd0;
    mem_ack_i      = 1'b0;
    mem_data_i     = 256'd0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    chk("rst ack", cache_ack_o, 1'b0);
    chk("rst cdata", cache_data_o, 256'd0);
    chk("rst men", mem_enable_o, 1'b0);
    chk("rst empty", empty_o, 1'b1);
    chk("rst full", full_o, 1'b0);

    // Single eviction, memory answers after 10 cycles.
    cache_req(1'b1, 32'h0000_0400, D_AA);
    wait_ack(lat);
    chk("evict ack lat", lat, 1);
    cache_enable_i = 1'b0;
    mem_serve("evict", 1'b1, 32'h0000_0400, 1'b1, D_AA, 10, 256'd0, lat);
    chk("evict drain lat", lat, 2);
    chk("evict empty", empty_o, 1'b1);

    // Back-to-back cache ops with memory stalled: forwarding, merge, fill.
    foreach (tbl[i]) begin
      cache_req(tbl[i].w, tbl[i].addr, tbl[i].data);
      wait_ack(lat);
      chk($sformatf("vec%0d lat", i), lat, int'(tbl[i].lat));
      if (!tbl[i].w) chk($sformatf("vec%0d rdata", i), cache_data_o, tbl[i].rdata);
      chk($sformatf("vec%0d men", i), mem_enable_o, 1'b0);
      chk($sformatf("vec%0d empty", i), empty_o, tbl[i].empty);
      chk($sformatf("vec%0d full", i), full_o, tbl[i].full);
    end

    // Fifth line while full: stalls until the head drains, then is pushed.
    cache_req(1'b1, 32'h0000_0080, D_E);
    mem_serve("full drain0", 1'b1, 32'h0000_0020, 1'b1, D_B, 3, 256'd0, lat);
    chk("full drain lat", lat, 2);
    chk("full no early ack", cache_ack_o, 1'b0);
    wait_ack(lat);
    chk("full push ack lat", lat, 1);
    chk("full after push", full_o, 1'b1);
    cache_enable_i = 1'b0;
    mem_serve("drain1", 1'b1, 32'h0000_0000, 1'b1, D_0, 0, 256'd0, lat);
    mem_serve("drain2", 1'b1, 32'h0000_0040, 1'b1, D_2, 0, 256'd0, lat);
    mem_serve("drain3", 1'b1, 32'h0000_0060, 1'b1, D_3, 1, 256'd0, lat);
    mem_serve("drain4", 1'b1, 32'h0000_0080, 1'b1, D_E, 0, 256'd0, lat);
    chk("drained empty", empty_o, 1'b1);

    // Read miss with two buffered lines goes to memory first.
    cache_req(1'b1, 32'h0000_0100, D_P);
    wait_ack(lat);
    chk("prio w0 lat", lat, 1);
    cache_req(1'b1, 32'h0000_0120, D_Q);
    wait_ack(lat);
    chk("prio w1 lat", lat, 2);
    cache_req(1'b0, 32'h0000_00E4, 256'd0);
    mem_serve("prio rd", 1'b0, 32'h0000_00E0, 1'b0, 256'd0, 2, D_R, lat);
    chk("prio rd lat", lat, 2);
    chk("prio rd ack", cache_ack_o, 1'b1);
    chk("prio rd data", cache_data_o, D_R);
    cache_enable_i = 1'b0;
    @(negedge clk_i);
    chk("rd ack pulse", cache_ack_o, 1'b0);
    chk("rd data held", cache_data_o, D_R);
    mem_serve("prio drain0", 1'b1, 32'h0000_0100, 1'b1, D_P, 0, 256'd0, lat);
    mem_serve("prio drain1", 1'b1, 32'h0000_0120, 1'b1, D_Q, 0, 256'd0, lat);
    chk("prio empty", empty_o, 1'b1);

    // Reset in the middle of a drain with two lines buffered.
    cache_req(1'b1, 32'h0000_0200, D_P);
    wait_ack(lat);
    cache_req(1'b1, 32'h0000_0220, D_Q);
    wait_ack(lat);
    cache_enable_i = 1'b0;
    lat = 0;
    while (!mem_enable_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    chk("rst pre en", mem_enable_o, 1'b1);
    chk("rst pre addr", mem_addr_o, 32'h0000_0200);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst mid men", mem_enable_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst2 ack", cache_ack_o, 1'b0);
    chk("rst2 cdata", cache_data_o, 256'd0);
    chk("rst2 mwr", mem_write_o, 1'b0);
    chk("rst2 maddr", mem_addr_o, 32'd0);
    chk("rst2 mdata", mem_data_o, 256'd0);
    chk("rst2 empty", empty_o, 1'b1);
    chk("rst2 full", full_o, 1'b0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk_i);
      if (mem_enable_o !== 1'b0) seen = 1'b1;
    end
    chk("rst no drain", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
